max31855_model: RTL and testbench

- Behavioural, synthesizable slave model of the MAX31855 thermocouple-to-digital converter, used as the SPI slave behind spi_master in simulation benches.
- Read-only slave: while chip select is low it shifts out one fixed 32-bit conversion frame, MSB first, on the MISO line. There is no MOSI input.
- All logic runs on the system clock. SCK and CS are sampled as synchronous inputs from the same clock domain, so no synchronizers are used.

---
 rtl/max31855_model_if.sv | 21 ++
 rtl/max31855_model.sv | 116 +++++++++++
 tb/tb_max31855_model.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/max31855_model_if.sv
// max31855_model_if -- SPI pins between a bus master and the MAX31855 slave model.
// The master drives chip select and serial clock; the slave drives MISO.
// Signal names follow the slave's pin names so both sides read the same.

interface max31855_model_if;
  logic i_sck;
  logic i_cs;
  logic o_so;

  modport master (
    output i_sck,
    output i_cs,
    input  o_so
  );

  modport slave (
    input  i_sck,
    input  i_cs,
    output o_so
  );
endinterface

// File: rtl/max31855_model.sv
// max31855_model -- synthesizable read-only slave model of the MAX31855
// thermocouple-to-digital converter.
//
// While chip select is low the model shifts out one 32-bit conversion frame,
// MSB first, on MISO. SCK and CS are sampled on the system clock (same clock
// domain as the master), so edges are found by comparing against the previous
// cycle's value and no synchronizers are needed.
//
// Optional feature, macro MAX31855_TEMP_RAMP_EN: when defined, the
// thermocouple field comes from a 14-bit register that starts at TC_TEMP and
// advances by one after every completely read frame (all 32 bits presented).
// When undefined the thermocouple field is the constant TC_TEMP.

module max31855_model #(
  parameter logic [13:0] TC_TEMP    = 14'd100,
  parameter logic [11:0] INT_TEMP   = 12'd400,
  parameter logic [2:0]  FAULT_BITS = 3'b000
) (
  input logic              i_system_clk,
  input logic              i_rst_n,
  max31855_model_if.slave  spi
);

  localparam logic [5:0] CNT_FULL = 6'd32;

  // Previous-cycle copies of the SPI inputs, used for edge detection.
  logic        cs_q;
  logic        sck_q;

  // Shift state: remaining frame bits, bits presented so far, frame in flight.
  logic [31:0] sr_q,     sr_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic        active_q, active_d;
  logic        so_q,     so_d;

  logic        cs_fall;
  logic        sck_fall;
  logic [13:0] tc_word;
  logic [31:0] frame;

  assign cs_fall  = cs_q & ~spi.i_cs;
  assign sck_fall = sck_q & ~spi.i_sck;

`ifdef MAX31855_TEMP_RAMP_EN
  logic        cs_rise;
  logic [13:0] tc_live_q, tc_live_d;

  assign cs_rise = ~cs_q & spi.i_cs;
  assign tc_word = tc_live_q;

  // Advance the live temperature only when the frame that just ended was read in full.
  always_comb begin
    tc_live_d = tc_live_q;
    if (cs_rise && active_q && (cnt_q == CNT_FULL)) begin
      tc_live_d = tc_live_q + 14'd1;
    end
  end

  // Live temperature register; restarts from the configured value on reset.
  always_ff @(posedge i_system_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tc_live_q <= TC_TEMP;
    end else begin
      tc_live_q <= tc_live_d;
    end
  end
`else
  assign tc_word = TC_TEMP;
`endif

  // The summary FAULT bit is the OR of the individual fault flags.
  assign frame = {tc_word, 1'b0, |FAULT_BITS, INT_TEMP, 1'b0, FAULT_BITS};

  // Next-state decode: CS high aborts, CS fall loads (beating a coincident SCK fall), SCK fall shifts.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    so_d     = so_q;
    if (spi.i_cs) begin
      active_d = 1'b0;
      so_d     = 1'b0;
    end else if (cs_fall) begin
      sr_d     = {frame[30:0], 1'b0};
      so_d     = frame[31];
      cnt_d    = 6'd1;
      active_d = 1'b1;
    end else if (sck_fall && active_q) begin
      so_d  = sr_q[31];
      sr_d  = {sr_q[30:0], 1'b0};
      cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 6'd1;
    end
  end

  // Register edge-detect history and shift state; reset forgets any frame in progress.
  always_ff @(posedge i_system_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_q     <= 1'b0;
      sck_q    <= 1'b0;
      sr_q     <= 32'd0;
      cnt_q    <= 6'd0;
      active_q <= 1'b0;
      so_q     <= 1'b0;
    end else begin
      cs_q     <= spi.i_cs;
      sck_q    <= spi.i_sck;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      so_q     <= so_d;
    end
  end

  assign spi.o_so = so_q;

endmodule

// File: tb/tb_max31855_model.sv
// tb_max31855_model -- bench for the MAX31855 slave model.
// Two instances share the SPI pins: one with default parameters and one with
// negative temperatures and fault flags set. Reads are mode-0 transfers with a
// randomized SCK half-period; each captured word is compared with a
// bit-by-bit reference built from the frame layout.

module tb_max31855_model;

  localparam logic [13:0] TC_A  = 14'd100;
  localparam logic [11:0] INT_A = 12'd400;
  localparam logic [2:0]  FLT_A = 3'b000;
  localparam logic [13:0] TC_B  = 14'h3FFC;
  localparam logic [11:0] INT_B = 12'hFF0;
  localparam logic [2:0]  FLT_B = 3'b101;

`ifdef MAX31855_TEMP_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic sck;
  logic cs;

  int vectors;
  int miscompares;

  logic [13:0] tcA, tcB;
  logic [63:0] lastA, lastB;

  max31855_model_if spiA ();
  max31855_model_if spiB ();

  assign spiA.i_sck = sck;
  assign spiA.i_cs  = cs;
  assign spiB.i_sck = sck;
  assign spiB.i_cs  = cs;

  max31855_model dutA (
    .i_system_clk (clk),
    .i_rst_n      (rst_n),
    .spi          (spiA)
  );

  max31855_model #(
    .TC_TEMP    (TC_B),
    .INT_TEMP   (INT_B),
    .FAULT_BITS (FLT_B)
  ) dutB (
    .i_system_clk (clk),
    .i_rst_n      (rst_n),
    .spi          (spiB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck bench still ends with a report.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] frameOf(input logic [13:0] tc, input logic [11:0] it,
                                          input logic [2:0] f);
    return {tc, 1'b0, (f != 3'b000), it, 1'b0, f};
  endfunction

  // Bits a master should capture in an n-bit read: the frame MSB first, then zeros.
  function automatic logic [63:0] expectedRead(input logic [31:0] fr, input int n);
    logic [63:0] e;
    e = 64'd0;
    for (int i = 0; i < n; i++) begin
      e = {e[62:0], (i < 32) ? fr[31 - i] : 1'b0};
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("resetSoA", {63'd0, spiA.o_so}, 64'd0);
    checkOutput("resetSoB", {63'd0, spiB.o_so}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    tcA = TC_A;
    tcB = TC_B;
  endtask

  // One mode-0 read of nBits; simul makes CS fall in the same cycle as an SCK fall.
  task automatic applyStimulus(input string tag, input int nBits, input int half, input bit simul);
    logic [63:0] capA, capB;
    capA = 64'd0;
    capB = 64'd0;
    if (simul) begin
      sck = 1'b1;
      tick(2);
      cs  = 1'b0;
      sck = 1'b0;
    end else begin
      cs = 1'b0;
    end
    tick(1);
    for (int i = 0; i < nBits; i++) begin
      capA = {capA[62:0], spiA.o_so};
      capB = {capB[62:0], spiB.o_so};
      sck = 1'b1;
      tick(half);
      sck = 1'b0;
      tick(half);
    end
    checkOutput({tag, "_wordA"}, capA, expectedRead(frameOf(tcA, INT_A, FLT_A), nBits));
    checkOutput({tag, "_wordB"}, capB, expectedRead(frameOf(tcB, INT_B, FLT_B), nBits));
    cs = 1'b1;
    tick(2);
    checkOutput({tag, "_idleA"}, {63'd0, spiA.o_so}, 64'd0);
    checkOutput({tag, "_idleB"}, {63'd0, spiB.o_so}, 64'd0);
    // The counter reaches 32 once the load plus 31 SCK falls have presented every bit.
    if (RAMP && nBits >= 31) begin
      tcA = tcA + 14'd1;
      tcB = tcB + 14'd1;
    end
    lastA = capA;
    lastB = capB;
  endtask

  initial begin
    logic [7:0] idleCap;
    logic [63:0] rstCap;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b1;
    cs    = 1'b1;
    sck   = 1'b0;
    tcA   = TC_A;
    tcB   = TC_B;
    tick(2);
    $display("[TB] reset and default frame");
    doReset();

    applyStimulus("full32", 32, 2, 1'b0);
    checkOutput("defaultFrame", {32'd0, lastA[31:0]}, 64'h0000_0000_0190_1900);
    checkOutput("faultFrame",   {32'd0, lastB[31:0]}, 64'h0000_0000_FFF1_FF05);

    $display("[TB] partial and over-long reads");
    doReset();
    applyStimulus("half16a", 16, 1, 1'b0);
    checkOutput("partialA1", {48'd0, lastA[15:0]}, 64'h0190);
    applyStimulus("half16b", 16, 1, 1'b0);
    checkOutput("partialA2", {48'd0, lastA[15:0]}, 64'h0190);
    applyStimulus("long48", 48, 1, 1'b0);

    $display("[TB] coincident CS and SCK falls, SCK with CS high");
    applyStimulus("simul", 32, 2, 1'b1);
    idleCap = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sck = ~sck;
      tick(1);
      idleCap = {idleCap[6:0], spiA.o_so | spiB.o_so};
    end
    sck = 1'b0;
    tick(1);
    checkOutput("sckCsHigh", {56'd0, idleCap}, 64'd0);

    $display("[TB] reset in the middle of a frame");
    cs = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1;
      tick(1);
      sck = 1'b0;
      tick(1);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midResetA", {63'd0, spiA.o_so}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tcA = TC_A;
    tcB = TC_B;
    rstCap = 64'd0;
    for (int i = 0; i < 22; i++) begin
      sck = 1'b1;
      tick(1);
      rstCap = {rstCap[62:0], spiA.o_so | spiB.o_so};
      sck = 1'b0;
      tick(1);
      rstCap = {rstCap[62:0], spiA.o_so | spiB.o_so};
    end
    checkOutput("csLowAtRelease", rstCap, 64'd0);
    cs = 1'b1;
    tick(2);
    applyStimulus("afterReset", 32, 1, 1'b0);

`ifdef MAX31855_TEMP_RAMP_EN
    $display("[TB] temperature ramp");
    doReset();
    applyStimulus("ramp0", 32, 1, 1'b0);
    checkOutput("ramp0Tc", {50'd0, lastA[31:18]}, {50'd0, TC_A});
    applyStimulus("rampAbort", 8, 1, 1'b0);
    applyStimulus("ramp1", 32, 1, 1'b0);
    checkOutput("ramp1Tc", {50'd0, lastA[31:18]}, {50'd0, TC_A + 14'd1});
    applyStimulus("ramp2", 32, 1, 1'b0);
    checkOutput("ramp2Tc", {50'd0, lastA[31:18]}, {50'd0, TC_A + 14'd2});
`endif

    $display("[TB] randomized reads");
    for (int k = 0; k < 20; k++) begin
      applyStimulus($sformatf("rand%0d", k), $urandom_range(1, 48),
                    $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
